prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/prog_loader_word_packer.sv | 48 ++++
 rtl/prog_loader.sv | 118 +++++++++++
 tb/tb_prog_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding
// and instruction-word geometry.
package prog_loader_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_e;

endpackage

// File: rtl/prog_loader_word_packer.sv
// Assembles incoming bytes into a little-endian 32-bit word; the first byte of
// a word ends up in bits [7:0] after the fourth shift.
module word_packer
    import prog_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_full_o
);

    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_d;

    // Byte counter and shift register next-state; the counter wraps after the fourth byte
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (byte_valid_i) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = {byte_i, word_q[WORD_W-1:8]};
        end else begin
            cnt_d  = cnt_q;
        end
    end

    // Packer state registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q  <= 2'd0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = byte_valid_i && !clear_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Streams program bytes into instruction memory one word at a time and holds
// the core in reset until a complete, length-checked load has finished.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DEPTH  = 80,
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [LEN_W-1:0]  len_words,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DEPTH);

    state_e             state_q;
    state_e             state_d;
    logic [ADDR_W-1:0]  idx_q;
    logic [ADDR_W-1:0]  idx_d;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_d;

    logic               pack_clear;
    logic               accept_byte;
    logic               word_full;
    logic               len_bad;
    logic               last_word;

    assign accept_byte = rx_valid && (state_q == RECV);
    assign len_bad     = (len_words == '0) || ({1'b0, len_words} > DEPTH_L);
    assign last_word   = (idx_q == ADDR_W'(len_q - LEN_W'(1)));

    word_packer u_packer (
        .clk_i        (CLK),
        .rst_n_i      (RST),
        .clear_i      (pack_clear),
        .byte_valid_i (accept_byte),
        .byte_i       (rx_data),
        .word_o       (wr_data),
        .word_full_o  (word_full)
    );

    // Next-state logic; start is only honoured from the idle/terminal states
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        pack_clear = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    if (len_bad) begin
                        state_d = ERR;
                    end else begin
                        state_d    = RECV;
                        len_d      = len_words;
                        idx_d      = '0;
                        pack_clear = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            RECV: begin
                if (word_full) begin
                    state_d = WRITE;
                end else begin
                    state_d = RECV;
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    state_d = RECV;
                    idx_d   = idx_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and load-context registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
        end
    end

    assign rx_ready   = (state_q == RECV);
    assign wr_en      = (state_q == WRITE);
    assign wr_addr    = idx_q;
    assign busy       = (state_q == RECV) || (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign err        = (state_q == ERR);
    assign core_rst_n = (state_q == DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued by the stimulus
// and a negedge monitor compares every wr_en strobe against the queue.
module tb_prog_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [15:0] len_words = 16'd0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  tests = 0;
    int  fails = 0;

    prog_loader dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .len_words  (len_words),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest queued expectation
    always @(negedge CLK) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0h data %h expected no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", wr_addr, mon_e.addr);
                chk("wr_data", {32'h0, wr_data}, {32'h0, mon_e.data});
            end
        end
    end

    task automatic pulse_start(input logic [15:0] len);
        len_words = len;
        start     = 1'b1;
        @(posedge CLK);
        #1 start  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        g        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        do begin
            @(negedge CLK);
            g++;
        end while (rx_ready !== 1'b1 && g < 100);
        if (rx_ready !== 1'b1) chk("rx_ready_timeout", {63'h0, rx_ready}, 64'h1);
        @(posedge CLK);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] addr, input logic [31:0] d);
        exp_q.push_back('{addr: addr, data: d});
        for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"},   {63'h0, rx_ready},   64'h0);
        chk({tag, "_wr_en"},      {63'h0, wr_en},      64'h0);
        chk({tag, "_wr_addr"},    wr_addr,             64'h0);
        chk({tag, "_wr_data"},    {32'h0, wr_data},    64'h0);
        chk({tag, "_busy"},       {63'h0, busy},       64'h0);
        chk({tag, "_done"},       {63'h0, done},       64'h0);
        chk({tag, "_err"},        {63'h0, err},        64'h0);
        chk({tag, "_core_rst_n"}, {63'h0, core_rst_n}, 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  iv;

        // Power-on reset
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("por");
        @(posedge CLK);
        #1 RST = 1'b1;

        // Two-word continuous load
        pulse_start(16'd2);
        chk("load2_busy", {63'h0, busy}, 64'h1);
        chk("load2_core_rst_n_low", {63'h0, core_rst_n}, 64'h0);
        send_word(64'd0, 32'h0000_0013);
        send_word(64'd1, 32'h0010_0093);
        @(negedge CLK);
        @(negedge CLK);
        chk("load2_done", {63'h0, done}, 64'h1);
        chk("load2_core_rst_n", {63'h0, core_rst_n}, 64'h1);
        chk("load2_busy_end", {63'h0, busy}, 64'h0);
        @(posedge CLK);
        #1;

        // Rejected lengths
        pulse_start(16'd0);
        chk("len0_err", {63'h0, err}, 64'h1);
        chk("len0_done", {63'h0, done}, 64'h0);
        chk("len0_core_rst_n", {63'h0, core_rst_n}, 64'h0);
        chk("len0_busy", {63'h0, busy}, 64'h0);
        repeat (3) @(posedge CLK);
        #1;
        pulse_start(16'd81);
        chk("len81_err", {63'h0, err}, 64'h1);
        chk("len81_core_rst_n", {63'h0, core_rst_n}, 64'h0);
        repeat (3) @(posedge CLK);
        #1;

        // Single word with a 5-cycle rx_valid gap after byte 2; clears err
        pulse_start(16'd1);
        chk("gap_err_cleared", {63'h0, err}, 64'h0);
        chk("gap_busy", {63'h0, busy}, 64'h1);
        exp_q.push_back('{addr: 64'd0, data: 32'h4433_2211});
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (5) begin
            @(posedge CLK);
            #1 chk("gap_rx_ready", {63'h0, rx_ready}, 64'h1);
        end
        send_byte(8'h33);
        send_byte(8'h44);
        chk("gap_write_rx_ready", {63'h0, rx_ready}, 64'h0);
        chk("gap_write_wr_en", {63'h0, wr_en}, 64'h1);
        @(posedge CLK);
        #1;
        chk("gap_done", {63'h0, done}, 64'h1);
        chk("gap_sb_empty", 64'(exp_q.size()), 64'h0);

        // Reset mid-load after 6 bytes of a 3-word load
        pulse_start(16'd3);
        send_word(64'd0, 32'h0403_0201);
        send_byte(8'h05);
        send_byte(8'h06);
        RST = 1'b0;
        @(posedge CLK);
        #1 check_reset_outputs("midrst");
        @(posedge CLK);
        #1 RST = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        chk("midrst_core_rst_n", {63'h0, core_rst_n}, 64'h0);
        chk("midrst_sb_empty", 64'(exp_q.size()), 64'h0);

        // Full-depth load with an ignored start pulse during RECV
        pulse_start(16'd80);
        for (int i = 0; i < 80; i++) begin
            iv = 8'(i);
            d  = {iv, 8'hC3, iv ^ 8'h5A, 8'd79 - iv};
            exp_q.push_back('{addr: 64'(i), data: d});
            send_byte(d[7:0]);
            send_byte(d[15:8]);
            if (i == 10) begin
                len_words = 16'd5;
                start     = 1'b1;
                @(posedge CLK);
                #1 start  = 1'b0;
                chk("ignored_start_busy", {63'h0, busy}, 64'h1);
                chk("ignored_start_rx_ready", {63'h0, rx_ready}, 64'h1);
            end
            send_byte(d[23:16]);
            send_byte(d[31:24]);
        end
        @(posedge CLK);
        #1;
        chk("full_done", {63'h0, done}, 64'h1);
        chk("full_core_rst_n", {63'h0, core_rst_n}, 64'h1);
        chk("full_busy", {63'h0, busy}, 64'h0);
        chk("full_wr_addr_max", wr_addr, 64'd79);
        chk("full_sb_empty", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
